floo_vc_link_buffer: RTL and testbench

Virtual-channel-aware link buffer inserted between two adjacent routers of a mesh. It provides per-VC elastic storage so that a stalled virtual channel never blocks the others on the shared physical flit lane. A fair round-robin arbiter multiplexes the VCs back onto a single physical output. This generalises the plain wire-level router-to-router connection with configurable VC count, per-VC depth and decoupled per-VC back-pressure.

---
 rtl/floo_vc_link_buffer.sv | 117 +++++++++++
 tb/tb_floo_vc_link_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_vc_link_buffer.sv
// rtl/floo_vc_link_buffer.sv - per-VC elastic link buffer with round-robin lane arbitration
module floo_vc_link_buffer #(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned FifoDepth       = 2,
    parameter type         flit_t          = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i,
    output logic [NumVirtChannels-1:0] valid_o,
    input  logic [NumVirtChannels-1:0] ready_i,
    output flit_t                      data_o
);

    localparam int unsigned PtrW = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1;
    localparam int unsigned IdxW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    flit_t            mem_q    [NumVirtChannels][FifoDepth];
    logic [IdxW-1:0]  rd_ptr_q [NumVirtChannels];
    logic [IdxW-1:0]  wr_ptr_q [NumVirtChannels];
    logic [CntW-1:0]  count_q  [NumVirtChannels];
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NumVirtChannels-1:0] cand;
    logic [NumVirtChannels-1:0] push;
    logic [NumVirtChannels-1:0] pop;
    logic                       grant_valid;
    logic [PtrW-1:0]            grant_idx;
    logic [31:0]                scan_idx;

    // Readiness and arbitration candidates come from registered counts only,
    // so a pop never makes room for a same-cycle push into a full FIFO.
    always_comb begin
        ready_o = '0;
        cand    = '0;
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            ready_o[v] = (count_q[v] != CntW'(FifoDepth));
            cand[v]    = (count_q[v] != '0) && ready_i[v];
        end
        push = valid_i & ready_o;
    end

    // Round-robin search starting at the priority pointer, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NumVirtChannels; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % NumVirtChannels;
            if (!grant_valid && cand[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PtrW'(scan_idx);
            end
        end
        valid_o  = '0;
        pop      = '0;
        data_o   = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            valid_o[grant_idx] = 1'b1;
            pop[grant_idx]     = 1'b1;
            data_o             = mem_q[grant_idx][rd_ptr_q[grant_idx]];
            rr_ptr_d = (grant_idx == PtrW'(NumVirtChannels - 1)) ? '0 : grant_idx + PtrW'(1);
        end
    end

    // Per-VC occupancy, read/write pointers and the arbiter priority pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int unsigned v = 0; v < NumVirtChannels; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned v = 0; v < NumVirtChannels; v++) begin
                if (push[v]) begin
                    wr_ptr_q[v] <= (wr_ptr_q[v] == IdxW'(FifoDepth - 1)) ? '0 : wr_ptr_q[v] + IdxW'(1);
                end
                if (pop[v]) begin
                    rd_ptr_q[v] <= (rd_ptr_q[v] == IdxW'(FifoDepth - 1)) ? '0 : rd_ptr_q[v] + IdxW'(1);
                end
                case ({push[v], pop[v]})
                    2'b10:   count_q[v] <= count_q[v] + CntW'(1);
                    2'b01:   count_q[v] <= count_q[v] - CntW'(1);
                    default: count_q[v] <= count_q[v];
                endcase
            end
        end
    end

    // Flit storage; contents are only observed while the matching count is non-zero.
    always_ff @(posedge clk_i) begin
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            if (push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= data_i;
            end
        end
    end

    // Upstream may offer at most one VC per cycle on the shared lane.
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(valid_i))
        else $error("valid_i has more than one bit set");

    // A pending offer must stay asserted until it is accepted.
    for (genvar gv = 0; gv < NumVirtChannels; gv++) begin : g_hold_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
                         (valid_i[gv] && !ready_o[gv]) |=> valid_i[gv])
            else $error("valid_i dropped before handshake");
    end

endmodule

// File: tb/tb_floo_vc_link_buffer.sv
// tb/tb_floo_vc_link_buffer.sv - self-checking bench for floo_vc_link_buffer
module tb_floo_vc_link_buffer;

    localparam int NVC   = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NVC-1:0]   valid_i, ready_o, valid_o, ready_i;
    logic [7:0]       data_i, data_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]     mq [NVC][$];
    int             rr;
    logic [NVC-1:0] exp_ready, exp_valid;
    logic [7:0]     exp_data;
    int             exp_grant;

    floo_vc_link_buffer #(
        .NumVirtChannels(NVC),
        .FifoDepth      (DEPTH),
        .flit_t         (logic [7:0])
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int v = 0; v < NVC; v++) mq[v].delete();
        rr = 0;
    endtask

    // Apply inputs on the falling edge and derive what the outputs must be.
    task automatic drive(input logic [NVC-1:0] v, input logic [7:0] d, input logic [NVC-1:0] r);
        int idx;
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        exp_valid = '0;
        exp_data  = '0;
        exp_grant = -1;
        for (int k = 0; k < NVC; k++) exp_ready[k] = (mq[k].size() != DEPTH);
        for (int i = 0; i < NVC; i++) begin
            idx = (rr + i) % NVC;
            if (exp_grant < 0 && mq[idx].size() != 0 && r[idx]) exp_grant = idx;
        end
        if (exp_grant >= 0) begin
            exp_valid[exp_grant] = 1'b1;
            exp_data = mq[exp_grant][0];
        end
    endtask

    // Advance one rising edge and apply the accepted push/pop to the model.
    task automatic tick();
        @(posedge clk);
        if (exp_grant >= 0) begin
            void'(mq[exp_grant].pop_front());
            rr = (exp_grant + 1) % NVC;
        end
        for (int k = 0; k < NVC; k++)
            if (valid_i[k] && exp_ready[k]) mq[k].push_back(data_i);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && n < 64) begin
            drive('0, 8'h00, '1);
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = '0; ready_i = '0; data_i = '0;
        #2;
        checks++;
        if (ready_o !== 4'hF || valid_o !== '0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_initial: ready_o=%h valid_o=%h data_o=%h want F/0/00", ready_o, valid_o, data_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        // mid-traffic reset: store flits on several VCs, then reset between edges
        drive(4'b0001, 8'hE1, '0); tick();
        drive(4'b0100, 8'hE2, '0); tick();
        drive(4'b0100, 8'hE3, '0); tick();
        @(negedge clk);
        valid_i = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 4'hF || valid_o !== '0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_async: ready_o=%h valid_o=%h data_o=%h want F/0/00", ready_o, valid_o, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int c = 0; c < 4; c++) begin
            drive('0, 8'h00, '1);
            checks++;
            if (valid_o !== '0 || data_o !== '0 || ready_o !== 4'hF) begin
                errors++;
                $display("FAIL reset_stale c%0d: valid_o=%h data_o=%h ready_o=%h want 0/00/F", c, valid_o, data_o, ready_o);
            end
            tick();
        end
    endtask

    task automatic test_single_vc_stream();
        logic [7:0] flits [3];
        flits[0] = 8'h11; flits[1] = 8'h22; flits[2] = 8'h33;
        for (int c = 0; c < 4; c++) begin
            drive((c < 3) ? 4'b0001 : 4'b0000, (c < 3) ? flits[c] : 8'h00, '1);
            checks++;
            if (c == 0) begin
                if (valid_o !== '0) begin
                    errors++;
                    $display("FAIL stream_latency: valid_o=%h want 0", valid_o);
                end
            end else if (valid_o !== 4'b0001 || data_o !== flits[c-1]) begin
                errors++;
                $display("FAIL stream c%0d: valid_o=%h data_o=%h want 1/%h", c, valid_o, data_o, flits[c-1]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_full_fifo();
        drive(4'b0010, 8'h51, '0); tick();
        drive(4'b0010, 8'h52, '0); tick();
        drive(4'b0010, 8'h53, '0);
        checks++;
        if (ready_o[1] !== 1'b0 || valid_o !== '0) begin
            errors++;
            $display("FAIL full_ready: ready_o[1]=%b valid_o=%h want 0/0", ready_o[1], valid_o);
        end
        tick();
        drive(4'b0010, 8'h53, 4'b0010);
        checks++;
        if (ready_o[1] !== 1'b0 || valid_o !== 4'b0010 || data_o !== 8'h51) begin
            errors++;
            $display("FAIL full_pop_no_push: ready_o[1]=%b valid_o=%h data_o=%h want 0/2/51", ready_o[1], valid_o, data_o);
        end
        tick();
        drive(4'b0010, 8'h53, 4'b0010);
        checks++;
        if (ready_o[1] !== 1'b1 || valid_o !== 4'b0010 || data_o !== 8'h52) begin
            errors++;
            $display("FAIL full_recover: ready_o[1]=%b valid_o=%h data_o=%h want 1/2/52", ready_o[1], valid_o, data_o);
        end
        tick();
        drive('0, 8'h00, 4'b0010);
        checks++;
        if (valid_o !== 4'b0010 || data_o !== 8'h53) begin
            errors++;
            $display("FAIL full_third: valid_o=%h data_o=%h want 2/53", valid_o, data_o);
        end
        tick();
        drain();
    endtask

    task automatic test_vc_isolation();
        logic [7:0] got [$];
        drive(4'b0001, 8'hC0, '0); tick();
        drive(4'b0001, 8'hC1, '0); tick();
        for (int c = 0; c < 9; c++) begin
            drive((c < 8) ? 4'b0010 : 4'b0000, 8'hA0 + 8'(c), 4'b0010);
            if (valid_o === 4'b0010) got.push_back(data_o);
            checks++;
            if (valid_o !== exp_valid || data_o !== exp_data || ready_o !== exp_ready) begin
                errors++;
                $display("FAIL isolation c%0d: valid_o=%h data_o=%h ready_o=%h want %h/%h/%h",
                         c, valid_o, data_o, ready_o, exp_valid, exp_data, exp_ready);
            end
            tick();
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL isolation_count: got %0d flits want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++)
                if (got[i] !== 8'hA0 + 8'(i)) begin
                    errors++;
                    $display("FAIL isolation_order %0d: got %h want %h", i, got[i], 8'hA0 + 8'(i));
                end
        end
        checks++;
        if (ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL isolation_vc0_held: ready_o[0]=%b want 0", ready_o[0]);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int seq_all [8];
        int seq_no2 [6];
        seq_all = '{0, 1, 2, 3, 0, 1, 2, 3};
        seq_no2 = '{0, 1, 3, 0, 1, 3};
        // restart from a known pointer
        @(negedge clk); rst_n = 1'b0; valid_i = '0; #1; @(negedge clk); rst_n = 1'b1;
        model_clear();
        for (int r = 0; r < DEPTH; r++)
            for (int v = 0; v < NVC; v++) begin
                drive(4'(1 << v), 8'(8'h40 + 8'(v * 4 + r)), '0); tick();
            end
        for (int c = 0; c < 8; c++) begin
            drive('0, 8'h00, '1);
            checks++;
            if (valid_o !== 4'(1 << seq_all[c]) || data_o !== exp_data) begin
                errors++;
                $display("FAIL rr_all c%0d: valid_o=%h data_o=%h want %h/%h", c, valid_o, data_o, 4'(1 << seq_all[c]), exp_data);
            end
            tick();
        end
        for (int r = 0; r < DEPTH; r++)
            for (int v = 0; v < NVC; v++) begin
                drive(4'(1 << v), 8'(8'h60 + 8'(v * 4 + r)), '0); tick();
            end
        for (int c = 0; c < 6; c++) begin
            drive('0, 8'h00, 4'b1011);
            checks++;
            if (valid_o !== 4'(1 << seq_no2[c]) || data_o !== exp_data) begin
                errors++;
                $display("FAIL rr_skip2 c%0d: valid_o=%h data_o=%h want %h/%h", c, valid_o, data_o, 4'(1 << seq_no2[c]), exp_data);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        logic [NVC-1:0] v, r;
        logic [7:0]     d;
        logic           hold;
        int             bad;
        hold = 1'b0; v = '0; d = '0; bad = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                if ($urandom_range(0, 3) == 0) v = '0;
                else v = 4'(1 << $urandom_range(0, NVC - 1));
                d = 8'($urandom);
            end
            r = 4'($urandom_range(0, 15));
            drive(v, d, r);
            checks++;
            if (valid_o !== exp_valid || data_o !== exp_data || ready_o !== exp_ready || (valid_o & ~ready_i) !== '0) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random c%0d: valid_o=%h data_o=%h ready_o=%h want %h/%h/%h",
                             c, valid_o, data_o, ready_o, exp_valid, exp_data, exp_ready);
                bad++;
            end
            hold = (v != '0) && ((v & exp_ready) == '0);
            tick();
        end
        if (hold) begin
            // keep the pending offer until it is taken
            for (int c = 0; c < 16 && hold; c++) begin
                drive(v, d, '1);
                hold = ((v & exp_ready) == '0);
                tick();
            end
        end
        drain();
        drive('0, 8'h00, '1);
        checks++;
        if (ready_o !== 4'hF || valid_o !== '0) begin
            errors++;
            $display("FAIL random_drain: ready_o=%h valid_o=%h want F/0", ready_o, valid_o);
        end
        tick();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_vc_stream();
        test_full_fifo();
        test_vc_isolation();
        test_round_robin();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
